fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// - Parametrised successor to the 2-source/2-stage forward select: picks the youngest ready producer
//   for each EXE source among NUM_STAGES downstream stages (stage 0 = MEM, youngest).
// - Adds load-use / not-ready stall detection and a scoreboard of in-flight multi-cycle writes (mul/div).
// - Adds a stall FSM with a watchdog; sits beside the EXE stage, drives the ALU forward muxes and the pipeline stall.
// PARAMETERS
// - NUM_SRC     2   EXE source operands per instruction (2 or 3)
// - NUM_STAGES  2   forwarding stages after EXE (1..4)
// - STALL_MAX   64  consecutive stall cycles before hazard_err (>=2)
// - SELW        $clog2(NUM_STAGES+1)  forward-select width (derived localparam, not overridable)
// PORTS
// - clk              in   1                   clock, rising edge
// - rst              in   1                   synchronous, active-high reset
// - exe_valid        in   1                   EXE holds a real instruction
// - exe_rs           in   NUM_SRC x 5         EXE source register indices
// - exe_rs_used      in   NUM_SRC             source actually read
// - stg_load_regfile in   NUM_STAGES          stage i will write rd
// - stg_rd           in   NUM_STAGES x 5      stage i destination
// - stg_ready        in   NUM_STAGES          stage i result value is available now (0 for a load awaiting data)
// - mc_issue         in   1                   multi-cycle op leaves EXE for the unit
// - mc_issue_rd      in   5                   its destination
// - mc_done          in   1                   multi-cycle result written to regfile this cycle
// - mc_done_rd       in   5                   its destination
// - fwd_sel          out  NUM_SRC x SELW      0 = regfile, k = stage k-1
// - stall_exe        out  1                   hold IF/ID/EXE, bubble into stage 0
// - hazard_err       out  1                   sticky watchdog flag
// - stall_count      out  32                  saturating count of stalled cycles
// BEHAVIOUR
// - Reset: pending[31:0]=0, state=RUN, wd_cnt=0, hazard_err=0, stall_count=0; outputs follow from those.
//   stall_exe is 0 during reset.
// - fwd_sel[s], combinational:
//   - Take the lowest i with stg_load_regfile[i], stg_rd[i]!=0 and stg_rd[i]==exe_rs[s]; fwd_sel[s]=i+1.
//   - If no stage matches, fwd_sel[s]=0.
//   - Younger stages always win. rd==x0 never forwards.
// - Hazard per source (exe_valid & exe_rs_used[s] & exe_rs[s]!=0):
//   - The matched stage has stg_ready==0, or
//   - there is no stage match and pending[exe_rs[s]]==1.
//   - A stage match masks the pending bit, because that in-flight write is younger.
// - stall_exe = OR of the per-source hazards, combinational, zero-latency.
//   fwd_sel remains valid while stalled.
// - Scoreboard, updated on the clock edge:
//   - mc_issue with mc_issue_rd!=0 sets pending[rd]; mc_done clears pending[mc_done_rd].
//   - Simultaneous issue and done to the same rd: set wins, because the new op is younger.
//   - Done to a non-pending rd is ignored. Bit 0 is never set.
//   - mc_issue while stall_exe=1 is ignored; the issuing instruction is held.
// - FSM, 2 states:
//   - RUN: stall_exe -> STALL, wd_cnt=1.
//   - STALL: stall_exe=0 -> RUN, wd_cnt=0. Otherwise wd_cnt++.
//   - Reaching wd_cnt==STALL_MAX sets hazard_err (sticky until rst) and wd_cnt holds.
//     Stalling continues; the unit never releases a stall on its own.
// - stall_count increments every cycle stall_exe=1 and saturates at 32'hFFFF_FFFF.
// - rst mid-stall: next cycle state=RUN and pending is cleared.
//   In-flight mc_done after reset is harmless because of the ignore rule.
// STRUCTURE
// - Shared pipeline package holds: typedef logic [4:0] reg_idx_t; fwd_sel_t sized by SELW; FWD_REGFILE=0.
// - Sub-module fwd_match_prio (one per source, generate loop): priority match -> {sel, hit, ready}.
// - Scoreboard, FSM and counters live in the top module.
// TESTING
// - No hazard: mem rd=5 ld=1 ready=1, exe_rs1=5 -> fwd_sel[0]=1, stall_exe=0.
//   Wb rd=5 only -> fwd_sel[0]=2.
// - Priority: stage0 and stage1 both rd=7, exe_rs2=7 -> fwd_sel[1]=1.
//   rd=0 in both stages with rs=0 -> fwd_sel=0, stall=0.
// - Load-use: stage0 rd=9 ready=0, exe_rs1=9 -> stall_exe=1 for 3 cycles.
//   After ready=1 -> stall=0, fwd_sel[0]=1, stall_count=3.
// - Scoreboard: mc_issue rd=12, then exe_rs1=12 -> stall until mc_done rd=12.
//   Same-cycle issue and done rd=12 -> pending[12] stays 1.
// - Watchdog: STALL_MAX=4, hold a hazard 6 cycles -> hazard_err rises on the 4th stalled cycle.
//   hazard_err stays 1 after the stall clears.
// - Reset mid-stall: pending[3]=1 and stalled, pulse rst -> next cycle stall_exe=0, hazard_err=0, stall_count=0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EXE forwarding / hazard unit.
// Register index, forward select encoding and stall FSM states.
package fwd_hazard_unit_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int SELW_MAX = 3;
  typedef logic [SELW_MAX-1:0] fwd_sel_t;

  localparam int FWD_REGFILE = 0;
  localparam reg_idx_t REG_X0 = 5'd0;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } stall_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EXE-side hazard bundle: operand/stage info in,
// forward selects, stall and status out.
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2
);
  localparam int SELW = $clog2(NUM_STAGES + 1);

  logic                                exe_valid;
  reg_idx_t [NUM_SRC-1:0]              exe_rs;
  logic     [NUM_SRC-1:0]              exe_rs_used;
  logic     [NUM_STAGES-1:0]           stg_load_regfile;
  reg_idx_t [NUM_STAGES-1:0]           stg_rd;
  logic     [NUM_STAGES-1:0]           stg_ready;
  logic                                mc_issue;
  reg_idx_t                            mc_issue_rd;
  logic                                mc_done;
  reg_idx_t                            mc_done_rd;
  logic     [NUM_SRC-1:0][SELW-1:0]    fwd_sel;
  logic                                stall_exe;
  logic                                hazard_err;
  logic     [31:0]                     stall_count;

  modport master (
    output exe_valid, exe_rs, exe_rs_used,
    output stg_load_regfile, stg_rd, stg_ready,
    output mc_issue, mc_issue_rd, mc_done, mc_done_rd,
    input  fwd_sel, stall_exe, hazard_err, stall_count
  );

  modport slave (
    input  exe_valid, exe_rs, exe_rs_used,
    input  stg_load_regfile, stg_rd, stg_ready,
    input  mc_issue, mc_issue_rd, mc_done, mc_done_rd,
    output fwd_sel, stall_exe, hazard_err, stall_count
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Priority match of one EXE source against downstream stages.
// Lowest (youngest) matching stage wins; x0 never matches.
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int SELW       = 2
) (
  input  reg_idx_t                  rs,
  input  logic     [NUM_STAGES-1:0] load,
  input  reg_idx_t [NUM_STAGES-1:0] rd,
  input  logic     [NUM_STAGES-1:0] ready,
  output logic     [SELW-1:0]       sel,
  output logic                      hit,
  output logic                      rdy
);

  always_comb begin
    sel = SELW'(FWD_REGFILE);
    hit = 1'b0;
    rdy = 1'b0;
    // scan oldest to youngest so the youngest match overwrites
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (load[i] && rd[i] != REG_X0 && rd[i] == rs) begin
        sel = SELW'(i + 1);
        hit = 1'b1;
        rdy = ready[i];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE forward select, load-use / multi-cycle hazard stall,
// in-flight write scoreboard and stall watchdog.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int STALL_MAX  = 64
) (
  input logic          clk,
  input logic          rst,
  fwd_hazard_unit_if.slave hz
);

  localparam int SELW = $clog2(NUM_STAGES + 1);
  localparam int WDW  = $clog2(STALL_MAX + 1);

  logic [31:0]                  pending;
  logic [31:0]                  pending_nxt;
  logic [NUM_SRC-1:0][SELW-1:0] sel;
  logic [NUM_SRC-1:0]           hit;
  logic [NUM_SRC-1:0]           rdy;
  logic [NUM_SRC-1:0]           haz;
  logic                         stall;

  stall_state_e   state;
  stall_state_e   state_nxt;
  logic [WDW-1:0] wd_cnt;
  logic [WDW-1:0] wd_nxt;
  logic           err_q;
  logic [31:0]    cnt_q;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match_prio #(
      .NUM_STAGES (NUM_STAGES),
      .SELW       (SELW)
    ) u_match (
      .rs    (hz.exe_rs[s]),
      .load  (hz.stg_load_regfile),
      .rd    (hz.stg_rd),
      .ready (hz.stg_ready),
      .sel   (sel[s]),
      .hit   (hit[s]),
      .rdy   (rdy[s])
    );

    // a stage match is younger than any in-flight mc write
    assign haz[s] = hz.exe_valid & hz.exe_rs_used[s]
                  & (hz.exe_rs[s] != REG_X0)
                  & (hit[s] ? ~rdy[s] : pending[hz.exe_rs[s]]);
  end

  assign stall          = (|haz) & ~rst;
  assign hz.fwd_sel     = sel;
  assign hz.stall_exe   = stall;
  assign hz.hazard_err  = err_q;
  assign hz.stall_count = cnt_q;

  always_comb begin
    pending_nxt = pending;
    if (hz.mc_done)
      pending_nxt[hz.mc_done_rd] = 1'b0;
    if (hz.mc_issue && !stall && hz.mc_issue_rd != REG_X0)
      pending_nxt[hz.mc_issue_rd] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd_cnt;
    unique case (state)
      ST_RUN: begin
        if (stall) begin
          state_nxt = ST_STALL;
          wd_nxt    = WDW'(1);
        end
      end
      ST_STALL: begin
        if (!stall) begin
          state_nxt = ST_RUN;
          wd_nxt    = '0;
        end else if (wd_cnt != WDW'(STALL_MAX)) begin
          wd_nxt = wd_cnt + WDW'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      state   <= ST_RUN;
      wd_cnt  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pending <= pending_nxt;
      state   <= state_nxt;
      wd_cnt  <= wd_nxt;
      if (wd_nxt == WDW'(STALL_MAX))
        err_q <= 1'b1;
      if (stall && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: vector table, directed
// sequences and randomized run against a reference model.
module tb_fwd_hazard_unit;

  localparam int NSRC = 2;
  localparam int NSTG = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(NSRC), .NUM_STAGES(NSTG)) hz ();

  fwd_hazard_unit #(
    .NUM_SRC    (NSRC),
    .NUM_STAGES (NSTG),
    .STALL_MAX  (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0]       m_pend;
  int              m_run;
  bit              m_err;
  longint unsigned m_cnt;

  typedef struct {
    logic       vld;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [1:0] ld;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [1:0] rdy;
    int         e_sel0;
    int         e_sel1;
    bit         e_stall;
  } vec_t;

  vec_t tbl[10];

  task automatic expect_eq(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int m_sel(int s);
    for (int i = 0; i < NSTG; i++)
      if (hz.stg_load_regfile[i] && hz.stg_rd[i] != 0
          && hz.stg_rd[i] == hz.exe_rs[s])
        return i + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (rst) return 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      int k;
      if (!(hz.exe_valid && hz.exe_rs_used[s] && hz.exe_rs[s] != 0))
        continue;
      k = m_sel(s);
      if (k != 0) begin
        if (!hz.stg_ready[k-1]) return 1'b1;
      end else if (m_pend[hz.exe_rs[s]]) begin
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_model();
    for (int s = 0; s < NSRC; s++)
      expect_eq($sformatf("m_sel%0d", s), 64'(hz.fwd_sel[s]), 64'(m_sel(s)));
    expect_eq("m_stall", 64'(hz.stall_exe), 64'(m_stall()));
    expect_eq("m_err", 64'(hz.hazard_err), 64'(m_err));
    expect_eq("m_cnt", 64'(hz.stall_count), 64'(m_cnt));
  endtask

  task automatic model_step();
    bit st;
    st = m_stall();
    if (rst) begin
      m_pend = '0;
      m_run  = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_run = st ? m_run + 1 : 0;
      if (m_run >= SMAX) m_err = 1'b1;
      if (hz.mc_done) m_pend[hz.mc_done_rd] = 1'b0;
      if (hz.mc_issue && !st && hz.mc_issue_rd != 0)
        m_pend[hz.mc_issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.exe_valid        = 1'b0;
    hz.exe_rs           = '0;
    hz.exe_rs_used      = '0;
    hz.stg_load_regfile = '0;
    hz.stg_rd           = '0;
    hz.stg_ready        = '0;
    hz.mc_issue         = 1'b0;
    hz.mc_issue_rd      = '0;
    hz.mc_done          = 1'b0;
    hz.mc_done_rd       = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_use(logic [4:0] r);
    hz.exe_valid           = 1'b1;
    hz.exe_rs[0]           = r;
    hz.exe_rs_used         = 2'b01;
    hz.stg_load_regfile[0] = 1'b1;
    hz.stg_rd[0]           = r;
    hz.stg_ready[0]        = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 5, 0, 2'b01, 2'b01, 5, 0, 2'b01, 1, 0, 0};
    tbl[1] = '{1, 5, 0, 2'b01, 2'b10, 0, 5, 2'b10, 2, 0, 0};
    tbl[2] = '{1, 0, 7, 2'b10, 2'b11, 7, 7, 2'b11, 0, 1, 0};
    tbl[3] = '{1, 0, 0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 0};
    tbl[4] = '{1, 9, 0, 2'b01, 2'b01, 9, 0, 2'b00, 1, 0, 1};
    tbl[5] = '{1, 9, 0, 2'b00, 2'b01, 9, 0, 2'b00, 1, 0, 0};
    tbl[6] = '{0, 9, 9, 2'b11, 2'b01, 9, 0, 2'b00, 1, 1, 0};
    tbl[7] = '{1, 4, 0, 2'b01, 2'b11, 4, 4, 2'b01, 1, 0, 0};
    tbl[8] = '{1, 0, 3, 2'b10, 2'b10, 0, 3, 2'b00, 0, 2, 1};
    tbl[9] = '{1, 6, 6, 2'b11, 2'b00, 6, 6, 2'b00, 0, 0, 0};

    clear_in();
    m_pend = '0;
    m_run  = 0;
    m_err  = 1'b0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    do_reset();

    #1;
    expect_eq("rst_stall", 64'(hz.stall_exe), 64'd0);
    expect_eq("rst_err", 64'(hz.hazard_err), 64'd0);
    expect_eq("rst_cnt", 64'(hz.stall_count), 64'd0);
    expect_eq("rst_sel", 64'(hz.fwd_sel), 64'd0);

    for (int v = 0; v < 10; v++) begin
      hz.exe_valid        = tbl[v].vld;
      hz.exe_rs[0]        = tbl[v].rs0;
      hz.exe_rs[1]        = tbl[v].rs1;
      hz.exe_rs_used      = tbl[v].used;
      hz.stg_load_regfile = tbl[v].ld;
      hz.stg_rd[0]        = tbl[v].rd0;
      hz.stg_rd[1]        = tbl[v].rd1;
      hz.stg_ready        = tbl[v].rdy;
      #1;
      expect_eq($sformatf("vec%0d_sel0", v), 64'(hz.fwd_sel[0]), 64'(tbl[v].e_sel0));
      expect_eq($sformatf("vec%0d_sel1", v), 64'(hz.fwd_sel[1]), 64'(tbl[v].e_sel1));
      expect_eq($sformatf("vec%0d_stall", v), 64'(hz.stall_exe), 64'(tbl[v].e_stall));
      tick();
    end

    // load-use held three cycles
    do_reset();
    load_use(5'd9);
    for (int c = 0; c < 3; c++) begin
      #1;
      expect_eq("lu_stall", 64'(hz.stall_exe), 64'd1);
      tick();
    end
    hz.stg_ready[0] = 1'b1;
    #1;
    expect_eq("lu_release", 64'(hz.stall_exe), 64'd0);
    expect_eq("lu_sel", 64'(hz.fwd_sel[0]), 64'd1);
    expect_eq("lu_cnt", 64'(hz.stall_count), 64'd3);
    tick();

    // scoreboard
    clear_in();
    hz.mc_issue    = 1'b1;
    hz.mc_issue_rd = 5'd12;
    tick();
    hz.mc_issue    = 1'b0;
    hz.exe_valid   = 1'b1;
    hz.exe_rs[0]   = 5'd12;
    hz.exe_rs_used = 2'b01;
    #1;
    expect_eq("sb_stall", 64'(hz.stall_exe), 64'd1);
    tick();
    tick();
    hz.mc_done    = 1'b1;
    hz.mc_done_rd = 5'd12;
    #1;
    expect_eq("sb_done_cyc", 64'(hz.stall_exe), 64'd1);
    tick();
    hz.mc_done = 1'b0;
    #1;
    expect_eq("sb_clear", 64'(hz.stall_exe), 64'd0);
    tick();

    clear_in();
    hz.mc_issue    = 1'b1;
    hz.mc_issue_rd = 5'd12;
    tick();
    hz.mc_done    = 1'b1;
    hz.mc_done_rd = 5'd12;
    tick();
    clear_in();
    hz.exe_valid   = 1'b1;
    hz.exe_rs[0]   = 5'd12;
    hz.exe_rs_used = 2'b01;
    #1;
    expect_eq("sb_set_wins", 64'(hz.stall_exe), 64'd1);
    hz.mc_done    = 1'b1;
    hz.mc_done_rd = 5'd12;
    tick();
    hz.mc_done = 1'b0;
    #1;
    expect_eq("sb_set_cleared", 64'(hz.stall_exe), 64'd0);
    tick();

    // watchdog at STALL_MAX=4
    do_reset();
    load_use(5'd9);
    for (int c = 0; c < 3; c++) tick();
    #1;
    expect_eq("wd_before", 64'(hz.hazard_err), 64'd0);
    tick();
    #1;
    expect_eq("wd_rise", 64'(hz.hazard_err), 64'd1);
    expect_eq("wd_still_stall", 64'(hz.stall_exe), 64'd1);
    tick();
    tick();
    hz.stg_ready[0] = 1'b1;
    #1;
    expect_eq("wd_release", 64'(hz.stall_exe), 64'd0);
    tick();
    #1;
    expect_eq("wd_sticky", 64'(hz.hazard_err), 64'd1);

    // reset while stalled on a pending write
    clear_in();
    hz.mc_issue    = 1'b1;
    hz.mc_issue_rd = 5'd3;
    tick();
    hz.mc_issue    = 1'b0;
    hz.exe_valid   = 1'b1;
    hz.exe_rs[0]   = 5'd3;
    hz.exe_rs_used = 2'b01;
    #1;
    expect_eq("rms_stall", 64'(hz.stall_exe), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    expect_eq("rms_in_rst", 64'(hz.stall_exe), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    expect_eq("rms_stall_after", 64'(hz.stall_exe), 64'd0);
    expect_eq("rms_err_after", 64'(hz.hazard_err), 64'd0);
    expect_eq("rms_cnt_after", 64'(hz.stall_count), 64'd0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst                 = ($urandom_range(0, 79) == 0);
      hz.exe_valid        = ($urandom_range(0, 7) != 0);
      hz.exe_rs[0]        = 5'($urandom_range(0, 7));
      hz.exe_rs[1]        = 5'($urandom_range(0, 7));
      hz.exe_rs_used      = 2'($urandom);
      hz.stg_load_regfile = 2'($urandom);
      hz.stg_rd[0]        = 5'($urandom_range(0, 7));
      hz.stg_rd[1]        = 5'($urandom_range(0, 7));
      hz.stg_ready        = 2'($urandom) | 2'($urandom);
      hz.mc_issue         = ($urandom_range(0, 3) == 0);
      hz.mc_issue_rd      = 5'($urandom_range(0, 7));
      hz.mc_done          = ($urandom_range(0, 2) == 0);
      hz.mc_done_rd       = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
